ps2_rx: RTL and testbench

//  Device-to-host PS/2 receiver: deserialises 11-bit frames clocked by a keyboard on PS2_CLK/PS2_DATA

---
 rtl/ps2_rx_pkg.sv | 27 ++
 rtl/ps2_rx_line_filter.sv | 62 ++++++
 rtl/ps2_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_pkg.sv
// ps2_rx_pkg -- shared PS/2 definitions.
// Holds the receiver FSM state type, frame geometry, the scancode prefix
// constants (break F0, extended E0) and an odd-parity helper. Intended to be
// shared by this receiver and later keymap / host-transmit blocks.
// No ports (package).
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // PS/2 uses odd parity: data bits plus parity bit contain an odd number of 1s.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_rx_line_filter.sv
// ps2_rx_line_filter -- synchroniser, glitch filter and falling-edge detector
// for one asynchronous PS/2 line.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset (filtered level resets high)
//   line_in  in  raw line, asynchronous to clk
//   fall     out one-cycle registered pulse on each falling edge of the
//                filtered level
// The filtered level only changes after FILTER_LEN consecutive synchronised
// samples disagree with it, so pulses shorter than FILTER_LEN cycles vanish.
module ps2_rx_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN) + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   fall_q, fall_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign fall   = fall_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], line_in};
    filt_d = filt_q;
    cnt_d  = '0;
    // Count the run of samples that disagree with the current level; any
    // agreeing sample restarts the run.
    if (synced != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx -- device-to-host PS/2 receiver (receive only, never drives lines).
// Deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop)
// into bytes with one-cycle strobes.
// Ports:
//   MCLK        in   system clock
//   RST         in   asynchronous active-high reset
//   PS2_CLK     in   raw PS/2 clock (async)
//   PS2_DATA    in   raw PS/2 data (async)
//   DATA        out  last good byte, held until the next VALID
//   VALID       out  one-cycle strobe, DATA updated
//   PARITY_ERR  out  one-cycle strobe, bad parity, frame dropped
//   FRAME_ERR   out  one-cycle strobe, stop bit 0 or mid-frame timeout
//   BUSY        out  FSM not idle
//   RELEASE     out  with VALID: byte was preceded by F0 (break filter build)
//   EXTENDED    out  with VALID: byte was preceded by E0 (break filter build)
// Build option: define PS2_RX_BREAK_FILTER_EN to swallow F0/E0 prefix bytes
// and report them as RELEASE/EXTENDED qualifiers on the following byte.
// Without it every good byte strobes VALID and the qualifiers are tied 0.
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       MCLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       BUSY,
  output logic       RELEASE,
  output logic       EXTENDED
);

  // Data is synchronised and then delayed by the filter's depth so that the
  // bit sampled on FALL is the one present at the raw clock edge.
  localparam int DLY  = SYNC_STAGES + FILTER_LEN;
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic fall;

  ps2_rx_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk    (MCLK),
    .rst    (RST),
    .line_in(PS2_CLK),
    .fall   (fall)
  );

  logic [DLY-1:0] dpipe_q, dpipe_d;
  logic           data_bit;
  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
  logic           busy_q, busy_d;
  logic           good_byte;

  assign data_bit = dpipe_q[DLY-1];

`ifdef PS2_RX_BREAK_FILTER_EN
  logic rel_q, rel_d;
  logic ext_q, ext_d;
  logic pend_rel_q, pend_rel_d;
  logic pend_ext_q, pend_ext_d;
`endif

  always_comb begin
    dpipe_d   = {dpipe_q[DLY-2:0], PS2_DATA};
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    good_byte = 1'b0;

    if (state_q == ST_IDLE || fall) begin
      to_d = '0;
    end else begin
      to_d = to_q + 1'b1;
    end

    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          // A high "start bit" is just line noise; stay put silently.
          if (!data_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = data_bit;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          // Bad stop bit outranks bad parity.
          if (!data_bit) begin
            ferr_d = 1'b1;
          end else if (odd_parity_ok(shift_q, parity_q)) begin
            good_byte = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && to_q == TO_W'(TIMEOUT_CYC - 1)) begin
      // Keyboard stopped clocking mid-frame: drop the partial byte.
      ferr_d  = 1'b1;
      state_d = ST_IDLE;
      to_d    = '0;
    end

`ifdef PS2_RX_BREAK_FILTER_EN
    rel_d      = 1'b0;
    ext_d      = 1'b0;
    pend_rel_d = pend_rel_q;
    pend_ext_d = pend_ext_q;
    if (good_byte) begin
      if (shift_q == PS2_BREAK) begin
        pend_rel_d = 1'b1;
      end else if (shift_q == PS2_EXT) begin
        pend_ext_d = 1'b1;
      end else begin
        valid_d    = 1'b1;
        data_d     = shift_q;
        rel_d      = pend_rel_q;
        ext_d      = pend_ext_q;
        pend_rel_d = 1'b0;
        pend_ext_d = 1'b0;
      end
    end
    // A corrupted frame may have been the byte the prefixes belonged to.
    if (perr_d || ferr_d) begin
      pend_rel_d = 1'b0;
      pend_ext_d = 1'b0;
    end
`else
    if (good_byte) begin
      valid_d = 1'b1;
      data_d  = shift_q;
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      dpipe_q    <= '1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      to_q       <= '0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PS2_RX_BREAK_FILTER_EN
      rel_q      <= 1'b0;
      ext_q      <= 1'b0;
      pend_rel_q <= 1'b0;
      pend_ext_q <= 1'b0;
`endif
    end else begin
      dpipe_q    <= dpipe_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      to_q       <= to_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef PS2_RX_BREAK_FILTER_EN
      rel_q      <= rel_d;
      ext_q      <= ext_d;
      pend_rel_q <= pend_rel_d;
      pend_ext_q <= pend_ext_d;
`endif
    end
  end

  assign DATA       = data_q;
  assign VALID      = valid_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;
  assign BUSY       = busy_q;
`ifdef PS2_RX_BREAK_FILTER_EN
  assign RELEASE    = rel_q;
  assign EXTENDED   = ext_q;
`else
  assign RELEASE    = 1'b0;
  assign EXTENDED   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx -- directed self-checking bench for ps2_rx.
// The PS/2 clock runs at 40 MCLK per bit and the timeout is shortened to 300
// cycles so the whole sequence stays short; data changes mid-high-phase.
module tb_ps2_rx;

  localparam int HALF    = 20;   // MCLK cycles per PS/2 clock phase
  localparam int TO_CYC  = 300;
  localparam int LATENCY = 2 + 4 + 1;

  logic       mclk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, busy, release_q, extended;

  int vectors = 0;
  int fails   = 0;

  int cyc = 0;
  int valid_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
  int valid_cyc = 0, overlap_cnt = 0, qual_bad = 0;
  logic last_rel = 1'b0, last_ext = 1'b0;
  int fall_cyc;

  ps2_rx #(
    .SYNC_STAGES(2),
    .FILTER_LEN (4),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .MCLK      (mclk),
    .RST       (rst),
    .PS2_CLK   (ps2_clk),
    .PS2_DATA  (ps2_data),
    .DATA      (data),
    .VALID     (valid),
    .PARITY_ERR(parity_err),
    .FRAME_ERR (frame_err),
    .BUSY      (busy),
    .RELEASE   (release_q),
    .EXTENDED  (extended)
  );

  always #20 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge away from DUT updates.
  always @(negedge mclk) begin
    if (valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
      last_rel  <= release_q;
      last_ext  <= extended;
    end
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
    if (int'(valid) + int'(parity_err) + int'(frame_err) > 1) overlap_cnt <= overlap_cnt + 1;
    if (!valid && (release_q || extended)) qual_bad <= qual_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // Sends the first nbits of frame {stop, parity, byte, start=0}, LSB first.
  task automatic send_frame(input logic [7:0] b, input logic p, input logic s, input int nbits);
    logic [10:0] f;
    f = {s, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      idle(HALF / 2);
      ps2_data = f[i];
      idle(HALF / 2);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      idle(HALF);
      ps2_clk  = 1'b1;
    end
    idle(HALF / 2);
    ps2_data = 1'b1;
    idle(HALF);
  endtask

  int v0, p0, f0;

  task automatic snap;
    v0 = valid_cnt;
    p0 = perr_cnt;
    f0 = ferr_cnt;
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    idle(3);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 0);
    check("rst_perr", 32'(parity_err), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rel_ext", 32'({release_q, extended}), 0);
    rst = 1'b0;
    idle(5);

    // 1: good 0x1C
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("t1_valid_cnt", 32'(valid_cnt - v0), 1);
    check("t1_err_cnt", 32'(perr_cnt - p0 + ferr_cnt - f0), 0);
    check("t1_data", 32'(data), 32'h1C);
    check("t1_busy", 32'(busy), 0);
    check("t1_latency", 32'(valid_cyc - fall_cyc), 32'(LATENCY));

    // 2: 0x29 with wrong parity
    snap();
    send_frame(8'h29, 1'b1, 1'b1, 11);
    check("t2_perr_cnt", 32'(perr_cnt - p0), 1);
    check("t2_valid_cnt", 32'(valid_cnt - v0), 0);
    check("t2_ferr_cnt", 32'(ferr_cnt - f0), 0);
    check("t2_data", 32'(data), 32'h1C);

    // 3: 0x75 with bad stop bit
    snap();
    send_frame(8'h75, 1'b0, 1'b0, 11);
    check("t3_ferr_cnt", 32'(ferr_cnt - f0), 1);
    check("t3_valid_cnt", 32'(valid_cnt - v0), 0);
    check("t3_perr_cnt", 32'(perr_cnt - p0), 0);
    check("t3_data", 32'(data), 32'h1C);

    // 4: partial frame then timeout, then a good 0x29
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 5);
    check("t4_busy_mid", 32'(busy), 1);
    check("t4_no_early_err", 32'(ferr_cnt - f0), 0);
    idle(TO_CYC + 100);
    check("t4_timeout_ferr", 32'(ferr_cnt - f0), 1);
    check("t4_busy_after", 32'(busy), 0);
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 11);
    check("t4_valid_cnt", 32'(valid_cnt - v0), 1);
    check("t4_data", 32'(data), 32'h29);

    // 5: short clock glitches with data low, then reset mid-frame
    snap();
    ps2_data = 1'b0;
    for (int g = 0; g < 3; g++) begin
      idle(10);
      ps2_clk = 1'b0;
      idle(2);
      ps2_clk = 1'b1;
    end
    idle(10);
    ps2_data = 1'b1;
    idle(TO_CYC + 100);
    check("t5_glitch_strobes", 32'(valid_cnt - v0 + perr_cnt - p0 + ferr_cnt - f0), 0);
    check("t5_glitch_busy", 32'(busy), 0);
    send_frame(8'h1C, 1'b0, 1'b1, 6);
    check("t5_busy_pre_rst", 32'(busy), 1);
    rst = 1'b1;
    idle(2);
    check("t5_busy_in_rst", 32'(busy), 0);
    check("t5_data_in_rst", 32'(data), 32'h00);
    rst = 1'b0;
    idle(TO_CYC + 100);
    check("t5_rst_strobes", 32'(valid_cnt - v0 + perr_cnt - p0 + ferr_cnt - f0), 0);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    check("t5_valid_cnt", 32'(valid_cnt - v0), 1);
    check("t5_data", 32'(data), 32'h1C);

    // 6: prefix streams
    snap();
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
`ifdef PS2_RX_BREAK_FILTER_EN
    check("t6a_valid_cnt", 32'(valid_cnt - v0), 1);
    check("t6a_data", 32'(data), 32'h1C);
    check("t6a_release", 32'(last_rel), 1);
    check("t6a_extended", 32'(last_ext), 0);
`else
    check("t6a_valid_cnt", 32'(valid_cnt - v0), 2);
    check("t6a_data", 32'(data), 32'h1C);
    check("t6a_quals", 32'({last_rel, last_ext}), 0);
`endif
    snap();
    send_frame(8'hE0, 1'b0, 1'b1, 11);
    send_frame(8'hF0, 1'b1, 1'b1, 11);
    send_frame(8'h75, 1'b0, 1'b1, 11);
`ifdef PS2_RX_BREAK_FILTER_EN
    check("t6b_valid_cnt", 32'(valid_cnt - v0), 1);
    check("t6b_data", 32'(data), 32'h75);
    check("t6b_release", 32'(last_rel), 1);
    check("t6b_extended", 32'(last_ext), 1);
`else
    check("t6b_valid_cnt", 32'(valid_cnt - v0), 3);
    check("t6b_data", 32'(data), 32'h75);
    check("t6b_quals", 32'({last_rel, last_ext}), 0);
`endif
    check("t6_errs", 32'(perr_cnt - p0 + ferr_cnt - f0), 0);

    check("strobe_overlap", 32'(overlap_cnt), 0);
    check("qual_without_valid", 32'(qual_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
